// File: rtl/alu_share_arb_if.sv
// alu_share_arb_if: one requester's view of the shared-ALU arbiter.
//   req_valid/req_ready      operation handshake (requester -> arbiter)
//   req_ctrl                 one-hot ALU op, bit 13..0 = add, addu, sub, subu,
//                            slt, sltu, and, nor, or, xor, sll, srl, sra, lui
//   req_src1/req_src2        operands (src1[4:0] = shift amount, src2[15:0] = lui imm)
//   rsp_valid/rsp_ready      result handshake (arbiter -> consumer)
//   rsp_result               buffered ALU result
// master = requester/consumer side, slave = arbiter side.
interface alu_share_arb_if;
  logic        req_valid;
  logic        req_ready;
  logic [13:0] req_ctrl;
  logic [31:0] req_src1;
  logic [31:0] req_src2;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;

  modport master (
    output req_valid, req_ctrl, req_src1, req_src2, rsp_ready,
    input  req_ready, rsp_valid, rsp_result
  );

  modport slave (
    input  req_valid, req_ctrl, req_src1, req_src2, rsp_ready,
    output req_ready, rsp_valid, rsp_result
  );
endinterface

// File: rtl/alu_share_arb.sv
// alu_share_arb: time-shares one ALU between two requesters with round-robin
// arbitration and a one-entry registered result buffer per port.
// Ports:
//   clk           system clock, all state on the rising edge
//   resetn        synchronous active-low reset
//   port0, port1  request/response channels (alu_share_arb_if.slave)
//   conflict_cnt  saturating count of cycles in which both ports were eligible
// Parameters:
//   RR_INIT       port holding priority after reset
//   CNT_W         width of conflict_cnt
module alu_share_arb #(
  parameter bit RR_INIT = 1'b0,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              resetn,
  alu_share_arb_if.slave    port0,
  alu_share_arb_if.slave    port1,
  output logic [CNT_W-1:0]  conflict_cnt
);

  logic [1:0]  elig;
  logic [1:0]  grant;
  logic        ptr;          // port that wins when both are eligible
  logic [1:0]  rsp_valid_q;
  logic [31:0] rsp_result_q [2];

  logic [13:0] alu_ctrl;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [31:0] alu_res;

  // A port may accept when its buffer is empty or is being drained this
  // cycle; the other port's backpressure never enters this term.
  assign elig[0] = port0.req_valid & (~rsp_valid_q[0] | port0.rsp_ready);
  assign elig[1] = port1.req_valid & (~rsp_valid_q[1] | port1.rsp_ready);

  // Gating with resetn keeps ready low while reset is asserted.
  assign grant[0] = resetn & elig[0] & (~elig[1] | ~ptr);
  assign grant[1] = resetn & elig[1] & (~elig[0] |  ptr);

  assign port0.req_ready  = grant[0];
  assign port1.req_ready  = grant[1];
  assign port0.rsp_valid  = rsp_valid_q[0];
  assign port1.rsp_valid  = rsp_valid_q[1];
  assign port0.rsp_result = rsp_result_q[0];
  assign port1.rsp_result = rsp_result_q[1];

  // Operand mux: zero operands when nobody is granted.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    alu_ctrl = '0;
    alu_a    = '0;
    alu_b    = '0;
    if (grant[0]) begin
      alu_ctrl = port0.req_ctrl;
      alu_a    = port0.req_src1;
      alu_b    = port0.req_src2;
    end else if (grant[1]) begin
      alu_ctrl = port1.req_ctrl;
      alu_a    = port1.req_src1;
      alu_b    = port1.req_src2;
    end
  end

  // Shared ALU. The if-chain gives the fixed priority (add group first, lui
  // last) that resolves a non-one-hot ctrl; ctrl = 0 yields 0.
  always_comb begin
    alu_res = '0;
    if (alu_ctrl[13] | alu_ctrl[12]) begin
      alu_res = alu_a + alu_b;
    end else if (alu_ctrl[11] | alu_ctrl[10]) begin
      alu_res = alu_a - alu_b;
    end else if (alu_ctrl[9]) begin
      alu_res = {31'b0, $signed(alu_a) < $signed(alu_b)};
    end else if (alu_ctrl[8]) begin
      alu_res = {31'b0, alu_a < alu_b};
    end else if (alu_ctrl[7]) begin
      alu_res = alu_a & alu_b;
    end else if (alu_ctrl[6]) begin
      alu_res = ~(alu_a | alu_b);
    end else if (alu_ctrl[5]) begin
      alu_res = alu_a | alu_b;
    end else if (alu_ctrl[4]) begin
      alu_res = alu_a ^ alu_b;
    end else if (alu_ctrl[3]) begin
      alu_res = alu_b << alu_a[4:0];
    end else if (alu_ctrl[2]) begin
      alu_res = alu_b >> alu_a[4:0];
    end else if (alu_ctrl[1]) begin
      alu_res = $unsigned($signed(alu_b) >>> alu_a[4:0]);
    end else if (alu_ctrl[0]) begin
      alu_res = {alu_b[15:0], 16'h0000};
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      // NOTE: the result buffers are cleared on reset as well, because their
      // contents are visible on rsp_result and must read 0 after reset.
      rsp_valid_q     <= '0;
      rsp_result_q[0] <= '0;
      rsp_result_q[1] <= '0;
      ptr             <= RR_INIT;
      conflict_cnt    <= '0;
    end else begin
      if (grant[0]) begin
        rsp_valid_q[0]  <= 1'b1;
        rsp_result_q[0] <= alu_res;
      end else if (port0.rsp_ready) begin
        rsp_valid_q[0]  <= 1'b0;
      end

      if (grant[1]) begin
        rsp_valid_q[1]  <= 1'b1;
        rsp_result_q[1] <= alu_res;
      end else if (port1.rsp_ready) begin
        rsp_valid_q[1]  <= 1'b0;
      end

      // Priority passes to the loser of every grant, even uncontested ones.
      if (grant[0]) begin
        ptr <= 1'b1;
      end else if (grant[1]) begin
        ptr <= 1'b0;
      end

      if ((elig == 2'b11) && (conflict_cnt != {CNT_W{1'b1}})) begin
        conflict_cnt <= conflict_cnt + 1'b1;
      end
    end
  end

endmodule
